// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencing FSM: steps the shared datapath through fetch/decode/exec/mem/wb.
// Outputs are combinational from state (plus mem_ready/opcode where noted); all forced to 0 while rst.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       Illegal,
  output logic       Retire,
  output logic [3:0] state
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8
  } state_t;

  state_t cur, nxt;

  always_ff @(posedge clk) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  always_comb begin
    nxt         = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    RegWrite    = 1'b0;
    Illegal     = 1'b0;
    Retire      = 1'b0;
    state       = cur;

    case (cur)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b10;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          nxt     = S_DECODE;
        end else begin
          nxt = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target computed from OldPC here and parked in ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        if (opcode == OP_LW || opcode == OP_SW) nxt = S_MEMADR;
        else if (opcode == OP_R)                nxt = S_EXECUTE;
        else if (opcode == OP_BEQ)              nxt = S_BRANCH;
        else begin
          Illegal = 1'b1;
          nxt     = S_FETCH;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (opcode == OP_LW)      nxt = S_MEMREAD;
        else if (opcode == OP_SW) nxt = S_MEMWRITE;
        else                      nxt = S_FETCH;
      end
      S_MEMREAD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        nxt     = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        Retire   = 1'b1;
        nxt      = S_FETCH;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          Retire = 1'b1;
          nxt    = S_FETCH;
        end else begin
          nxt = S_MEMWRITE;
        end
      end
      S_EXECUTE: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b10;
        nxt     = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        Retire   = 1'b1;
        nxt      = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 2'b10;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        Retire      = 1'b1;
        nxt         = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase

    // Reset masks every output so no write enable leaks in the reset cycle.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSource    = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      RegWrite    = 1'b0;
      Illegal     = 1'b0;
      Retire      = 1'b0;
      state       = 4'd0;
    end
  end

endmodule
